fetch_queue_unit: RTL

Parametrised instruction-fetch front end: owns the program counter, issues word-aligned reads to a fixed-latency instruction memory, and buffers returned instructions in a small FIFO. It presents `{pc, instr}` plus decoded register fields to decode over a valid/ready handshake. It supports redirect (branch/jump), which flushes buffered and in-flight fetches. It sits between the instruction ROM and the decode/register-read stage, replacing the free-running PC/+4/ROM chain.

---
 rtl/fetch_queue_unit.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: owns the PC, issues word-aligned reads to a
// one-cycle-latency instruction memory and queues returned words for decode.
module fetch_queue_unit #(
    parameter int                ADDR_W   = 8,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              dec_valid,
    input  logic              dec_ready,
    output logic [ADDR_W-1:0] dec_pc,
    output logic [31:0]       dec_instr,
    output logic [4:0]        dec_rd,
    output logic [4:0]        dec_rs1,
    output logic [4:0]        dec_rs2
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1'b1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1'b1);
    localparam logic [CNT_W:0]    DEPTH_C   = (CNT_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] ADDR_FOUR = ADDR_W'(3'd4);

    logic [ADDR_W-1:0] fetch_pc_r;
    logic [ADDR_W-1:0] inflight_pc_r;
    logic              inflight_r;
    logic              kill_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic [ADDR_W-1:0] pc_mem_r    [DEPTH];
    logic [31:0]       instr_mem_r [DEPTH];

    logic              credit_s;
    logic              issue_s;
    logic              push_s;
    logic              pop_s;
    logic              full_s;
    logic [ADDR_W-1:0] head_pc_s;
    logic [31:0]       head_instr_s;

    // Occupancy counts the outstanding response so the queue can never overflow.
    assign credit_s  = ({1'b0, count_r} + {{CNT_W{1'b0}}, inflight_r}) < DEPTH_C;
    assign issue_s   = !rst && !redirect_valid && credit_s;
    assign push_s    = inflight_r && !kill_r && !redirect_valid;
    assign dec_valid = !rst && (count_r != {CNT_W{1'b0}});
    assign pop_s     = dec_valid && dec_ready && !redirect_valid;
    assign full_s    = (count_r == DEPTH_C[CNT_W-1:0]);

    assign imem_req  = issue_s;
    assign imem_addr = fetch_pc_r;

    assign head_pc_s    = pc_mem_r[rd_ptr_r];
    assign head_instr_s = instr_mem_r[rd_ptr_r];

    // PC, in-flight tracking and queue bookkeeping; redirect outranks push/pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_r    <= {RESET_PC[ADDR_W-1:2], 2'b00};
            inflight_pc_r <= {ADDR_W{1'b0}};
            inflight_r    <= 1'b0;
            kill_r        <= 1'b0;
            rd_ptr_r      <= {PTR_W{1'b0}};
            wr_ptr_r      <= {PTR_W{1'b0}};
            count_r       <= {CNT_W{1'b0}};
        end else if (redirect_valid) begin
            fetch_pc_r    <= {redirect_pc[ADDR_W-1:2], 2'b00};
            inflight_r    <= 1'b0;
            kill_r        <= 1'b1;
            rd_ptr_r      <= {PTR_W{1'b0}};
            wr_ptr_r      <= {PTR_W{1'b0}};
            count_r       <= {CNT_W{1'b0}};
        end else begin
            kill_r     <= 1'b0;
            inflight_r <= issue_s;
            if (issue_s) begin
                fetch_pc_r    <= fetch_pc_r + ADDR_FOUR;
                inflight_pc_r <= fetch_pc_r;
            end else begin
                fetch_pc_r    <= fetch_pc_r;
                inflight_pc_r <= inflight_pc_r;
            end
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Queue payload storage; only entries below count are ever observed.
    always_ff @(posedge clk) begin
        if (!rst && push_s) begin
            pc_mem_r[wr_ptr_r]    <= inflight_pc_r;
            instr_mem_r[wr_ptr_r] <= imem_rdata;
        end
    end

    // Empty queue or reset presents zeros rather than stale entries.
    always_comb begin
        dec_pc    = {ADDR_W{1'b0}};
        dec_instr = 32'd0;
        if (dec_valid) begin
            dec_pc    = head_pc_s;
            dec_instr = head_instr_s;
        end else begin
            dec_pc    = {ADDR_W{1'b0}};
            dec_instr = 32'd0;
        end
    end

    assign dec_rd  = dec_instr[11:7];
    assign dec_rs1 = dec_instr[19:15];
    assign dec_rs2 = dec_instr[24:20];

    fetch_queue_unit_chk u_chk (
        .clk  (clk),
        .rst  (rst),
        .push (push_s),
        .full (full_s)
    );

endmodule

// Invariant checker: the credit scheme must never deliver into a full queue.
module fetch_queue_unit_chk (
    input logic clk,
    input logic rst,
    input logic push,
    input logic full
);

    // A push into a full queue would overwrite an undelivered instruction.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && full)) else $error("fetch queue overflow");
        end
    end

endmodule
